// File: rtl/fpu_issue.sv
// FPU issue/writeback sequencer: resolves rounding mode, launches one op at a time
// to the execute unit and drains results through a 2-entry writeback buffer.
module fpu_issue #(
  parameter int unsigned OP_W        = 5,
  parameter int unsigned EXE_TIMEOUT = 256
) (
  input  logic            clock_i,
  input  logic            reset_i,
  input  logic            issue_valid_i,
  output logic            issue_ready_o,
  input  logic [OP_W-1:0] issue_op_i,
  input  logic [31:0]     issue_data1_i,
  input  logic [31:0]     issue_data2_i,
  input  logic [31:0]     issue_data3_i,
  input  logic [2:0]      issue_rm_i,
  input  logic            issue_fpuc_i,
  input  logic            issue_fpuf_i,
  input  logic            issue_fwren_i,
  input  logic            issue_wren_i,
  input  logic [4:0]      issue_waddr_i,
  input  logic [2:0]      frm_i,
  input  logic [4:0]      cur_fflags_i,
  output logic            exe_enable_o,
  output logic [OP_W-1:0] exe_op_o,
  output logic [31:0]     exe_data1_o,
  output logic [31:0]     exe_data2_o,
  output logic [31:0]     exe_data3_o,
  output logic [2:0]      exe_rm_o,
  input  logic            exe_ready_i,
  input  logic [31:0]     exe_result_i,
  input  logic [4:0]      exe_flags_i,
  output logic            fwb_wren_o,
  output logic            iwb_wren_o,
  output logic [4:0]      wb_waddr_o,
  output logic [31:0]     wb_wdata_o,
  input  logic            wb_ready_i,
  output logic            flags_valid_o,
  output logic [4:0]      flags_o,
  input  logic            kill_i,
  output logic            illegal_o,
  output logic            timeout_o,
  output logic            busy_o
);

  // state | meaning
  // IDLE  | waiting for an operation; accepts when the buffer has room
  // EXEC  | exe_enable pulse cycle; result may already be ready
  // WAIT  | waiting for exe_ready, guarded by the watchdog
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;

  localparam int unsigned         CNT_W    = $clog2(EXE_TIMEOUT);
  localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(EXE_TIMEOUT - 1);

  typedef struct packed {
    logic        fwren;
    logic        wren;
    logic [4:0]  waddr;
    logic [31:0] data;
    logic [4:0]  flags;
    logic        fpuf;
  } wb_entry_t;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             illegal_q, illegal_d;
  logic             timeout_q, timeout_d;
  logic             run_q;

  logic [OP_W-1:0]  op_q;
  logic [31:0]      data1_q, data2_q, data3_q;
  logic [2:0]       rm_q;
  logic             fwren_q, wren_q, fpuf_q;
  logic [4:0]       waddr_q;

  wb_entry_t        buf_q [2];
  logic             rd_ptr_q, wr_ptr_q;
  logic [1:0]       count_q;

  logic             accept, load, push, pop, nonempty, rm_illegal;
  logic [2:0]       rm_res;
  wb_entry_t        head, push_entry;

  assign rm_res     = (issue_rm_i == 3'd7) ? frm_i : issue_rm_i;
  assign rm_illegal = issue_fpuc_i & (rm_res >= 3'd5);

  // run_q keeps issue_ready low while reset is held, since IDLE alone would raise it
  assign issue_ready_o = run_q & (state_q == S_IDLE) & (count_q != 2'd2) & ~kill_i;
  assign accept        = issue_valid_i & issue_ready_o;
  assign load          = accept & ~rm_illegal;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    illegal_d = 1'b0;
    timeout_d = 1'b0;
    push      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (rm_illegal) begin
            illegal_d = 1'b1;
          end else begin
            state_d = S_EXEC;
            cnt_d   = '0;
          end
        end
      end
      S_EXEC: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (kill_i) begin
          state_d = S_IDLE;
        end else if (exe_ready_i) begin
          push    = 1'b1;
          state_d = S_IDLE;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (kill_i) begin
          state_d = S_IDLE;
        end else if (exe_ready_i) begin
          push    = 1'b1;
          state_d = S_IDLE;
        end else if (cnt_q == CNT_LAST) begin
          timeout_d = 1'b1;
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
      run_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      illegal_q <= illegal_d;
      timeout_q <= timeout_d;
      run_q     <= 1'b1;
    end
  end

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      op_q    <= '0;
      data1_q <= '0;
      data2_q <= '0;
      data3_q <= '0;
      rm_q    <= '0;
      fwren_q <= 1'b0;
      wren_q  <= 1'b0;
      fpuf_q  <= 1'b0;
      waddr_q <= '0;
    end else if (load) begin
      op_q    <= issue_op_i;
      data1_q <= issue_data1_i;
      data2_q <= issue_data2_i;
      data3_q <= issue_data3_i;
      rm_q    <= issue_fpuc_i ? rm_res : issue_rm_i;
      fwren_q <= issue_fwren_i;
      wren_q  <= issue_wren_i;
      fpuf_q  <= issue_fpuf_i;
      waddr_q <= issue_waddr_i;
    end
  end

  assign push_entry = '{fwren: fwren_q, wren: wren_q, waddr: waddr_q,
                        data: exe_result_i, flags: exe_flags_i, fpuf: fpuf_q};
  assign nonempty   = (count_q != 2'd0);
  assign head       = buf_q[rd_ptr_q];
  assign pop        = wb_ready_i & nonempty;

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      buf_q[0] <= '0;
      buf_q[1] <= '0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push) begin
        buf_q[wr_ptr_q] <= push_entry;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign exe_enable_o  = (state_q == S_EXEC);
  assign exe_op_o      = op_q;
  assign exe_data1_o   = data1_q;
  assign exe_data2_o   = data2_q;
  assign exe_data3_o   = data3_q;
  assign exe_rm_o      = rm_q;

  assign fwb_wren_o    = head.fwren & nonempty;
  assign iwb_wren_o    = head.wren & nonempty;
  assign wb_waddr_o    = nonempty ? head.waddr : 5'd0;
  assign wb_wdata_o    = nonempty ? head.data : 32'd0;
  assign flags_valid_o = pop & head.fpuf;
  assign flags_o       = flags_valid_o ? (cur_fflags_i | head.flags) : 5'd0;

  assign illegal_o     = illegal_q;
  assign timeout_o     = timeout_q;
  assign busy_o        = (state_q != S_IDLE) | nonempty;

endmodule

// File: tb/tb_fpu_issue.sv
// Directed bench for fpu_issue: hand-computed expectations for issue, rm resolution,
// backpressure, kill, watchdog and asynchronous reset.
module tb_fpu_issue;

  logic        clk, rst;
  logic        issue_valid, issue_ready;
  logic [4:0]  issue_op;
  logic [31:0] issue_data1, issue_data2, issue_data3;
  logic [2:0]  issue_rm, frm;
  logic        issue_fpuc, issue_fpuf, issue_fwren, issue_wren;
  logic [4:0]  issue_waddr, cur_fflags;
  logic        exe_enable;
  logic [4:0]  exe_op;
  logic [31:0] exe_data1, exe_data2, exe_data3;
  logic [2:0]  exe_rm;
  logic        exe_ready;
  logic [31:0] exe_result;
  logic [4:0]  exe_flags;
  logic        fwb_wren, iwb_wren;
  logic [4:0]  wb_waddr;
  logic [31:0] wb_wdata;
  logic        wb_ready, flags_valid;
  logic [4:0]  flags;
  logic        kill, illegal, timeout, busy;

  int n_checks = 0;
  int n_errors = 0;

  fpu_issue dut (
    .clock_i(clk), .reset_i(rst),
    .issue_valid_i(issue_valid), .issue_ready_o(issue_ready), .issue_op_i(issue_op),
    .issue_data1_i(issue_data1), .issue_data2_i(issue_data2), .issue_data3_i(issue_data3),
    .issue_rm_i(issue_rm), .issue_fpuc_i(issue_fpuc), .issue_fpuf_i(issue_fpuf),
    .issue_fwren_i(issue_fwren), .issue_wren_i(issue_wren), .issue_waddr_i(issue_waddr),
    .frm_i(frm), .cur_fflags_i(cur_fflags),
    .exe_enable_o(exe_enable), .exe_op_o(exe_op),
    .exe_data1_o(exe_data1), .exe_data2_o(exe_data2), .exe_data3_o(exe_data3),
    .exe_rm_o(exe_rm), .exe_ready_i(exe_ready), .exe_result_i(exe_result),
    .exe_flags_i(exe_flags),
    .fwb_wren_o(fwb_wren), .iwb_wren_o(iwb_wren), .wb_waddr_o(wb_waddr),
    .wb_wdata_o(wb_wdata), .wb_ready_i(wb_ready),
    .flags_valid_o(flags_valid), .flags_o(flags),
    .kill_i(kill), .illegal_o(illegal), .timeout_o(timeout), .busy_o(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #50000;
    $display("FAIL global_time_limit: got expired expected finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Launch an FP-destination op and return exe_ready `lat` cycles after the enable cycle.
  task automatic do_op(input logic [4:0] waddr, input logic [31:0] res,
                       input logic [4:0] fl, input logic fpuf, input int lat);
    issue_valid = 1'b1; issue_waddr = waddr; issue_fpuf = fpuf;
    issue_fwren = 1'b1; issue_wren = 1'b0; issue_rm = 3'd0; issue_fpuc = 1'b1;
    #1 check("op_accept_rdy", issue_ready, 1);
    step();
    issue_valid = 1'b0;
    repeat (lat) step();
    exe_ready = 1'b1; exe_result = res; exe_flags = fl;
    step();
    exe_ready = 1'b0;
  endtask

  int first;
  int i;

  initial begin
    rst = 1'b0;
    issue_valid = 0; issue_op = 0; issue_data1 = 0; issue_data2 = 0; issue_data3 = 0;
    issue_rm = 0; issue_fpuc = 0; issue_fpuf = 0; issue_fwren = 0; issue_wren = 0;
    issue_waddr = 0; frm = 0; cur_fflags = 5'h1f; exe_ready = 0; exe_result = 0;
    exe_flags = 0; wb_ready = 1; kill = 0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_issue_ready", issue_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_flags", {flags_valid, flags}, 0);
    check("rst_exe_enable", exe_enable, 0);
    rst = 1'b1;
    step();
    check("post_rst_ready", issue_ready, 1);
    kill = 1'b1;
    #1 check("kill_idle_blocks", issue_ready, 0);
    kill = 1'b0;

    // fadd, single-cycle
    cur_fflags = 5'h10; issue_valid = 1; issue_op = 5'd1;
    issue_data1 = 32'h3f800000; issue_data2 = 32'h40000000; issue_data3 = 32'h0;
    issue_rm = 3'd0; frm = 3'd2; issue_fpuc = 1; issue_fpuf = 1;
    issue_fwren = 1; issue_wren = 0; issue_waddr = 5'd3;
    #1 check("fadd_rdy", issue_ready, 1);
    step();
    issue_valid = 0; exe_ready = 1; exe_result = 32'h40400000; exe_flags = 5'h01;
    #1;
    check("fadd_enable", exe_enable, 1);
    check("fadd_op", exe_op, 5'd1);
    check("fadd_data1", exe_data1, 32'h3f800000);
    check("fadd_data2", exe_data2, 32'h40000000);
    check("fadd_rm", exe_rm, 3'd0);
    check("fadd_no_early_wb", fwb_wren, 0);
    step();
    exe_ready = 0;
    #1;
    check("fadd_enable_1cyc", exe_enable, 0);
    check("fadd_fwb", {fwb_wren, iwb_wren}, 2'b10);
    check("fadd_waddr", wb_waddr, 5'd3);
    check("fadd_wdata", wb_wdata, 32'h40400000);
    check("fadd_flags_valid", flags_valid, 1);
    check("fadd_flags", flags, 5'h11);
    check("fadd_next_ready", issue_ready, 1);
    step();
    check("fadd_drained", {busy, fwb_wren, flags_valid}, 3'b000);

    // Dynamic rm from frm, integer destination
    issue_valid = 1; issue_rm = 3'd7; frm = 3'd3; issue_fpuc = 1; issue_fpuf = 0;
    issue_fwren = 0; issue_wren = 1; issue_waddr = 5'd7;
    step();
    issue_valid = 0; exe_ready = 1; exe_result = 32'h00001234; exe_flags = 5'h1f;
    #1;
    check("dyn_rm", exe_rm, 3'd3);
    check("dyn_enable", exe_enable, 1);
    step();
    exe_ready = 0;
    #1;
    check("dyn_iwb", {fwb_wren, iwb_wren}, 2'b01);
    check("dyn_waddr", wb_waddr, 5'd7);
    check("dyn_wdata", wb_wdata, 32'h00001234);
    check("dyn_no_flags", flags_valid, 0);
    step();

    // fpuc=0 passes rm through unchanged, even an otherwise illegal value
    issue_valid = 1; issue_rm = 3'd6; issue_fpuc = 0; issue_wren = 0; issue_fwren = 0;
    step();
    issue_valid = 0; exe_ready = 1;
    #1;
    check("nofpuc_rm", exe_rm, 3'd6);
    check("nofpuc_not_illegal", {illegal, exe_enable}, 2'b01);
    step();
    exe_ready = 0;
    step();
    check("nofpuc_idle", busy, 0);

    // Illegal rm: frm=5 selected through issue_rm=7
    issue_valid = 1; issue_rm = 3'd7; frm = 3'd5; issue_fpuc = 1;
    #1 check("ill_rdy", issue_ready, 1);
    step();
    issue_valid = 0;
    #1;
    check("ill_pulse", illegal, 1);
    check("ill_no_enable", exe_enable, 0);
    check("ill_not_busy", busy, 0);
    step();
    check("ill_pulse_end", {illegal, exe_enable, busy}, 3'b000);

    // Backpressure: two fdiv ops fill the buffer, then drain in order
    wb_ready = 0;
    do_op(5'd10, 32'h000000d1, 5'h02, 1'b1, 10);
    #1;
    check("bp_head1", {fwb_wren, wb_wdata}, {1'b1, 32'h000000d1});
    check("bp_ready_cnt1", issue_ready, 1);
    check("bp_no_flags_held", flags_valid, 0);
    do_op(5'd11, 32'h000000d2, 5'h04, 1'b1, 10);
    #1;
    check("bp_full_not_ready", issue_ready, 0);
    check("bp_head_still1", wb_waddr, 5'd10);
    wb_ready = 1;
    #1;
    check("bp_pop1", {fwb_wren, wb_waddr}, {1'b1, 5'd10});
    check("bp_flags1", {flags_valid, flags}, {1'b1, 5'h12});
    step();
    check("bp_pop2", {wb_waddr, wb_wdata}, {5'd11, 32'h000000d2});
    check("bp_flags2", {flags_valid, flags}, {1'b1, 5'h14});
    step();
    check("bp_drained", {busy, issue_ready, fwb_wren}, 3'b010);

    // Kill in WAIT with an entry already buffered
    wb_ready = 0;
    do_op(5'd20, 32'h0000aaaa, 5'h0, 1'b0, 0);
    issue_valid = 1; issue_waddr = 5'd21;
    #1 check("kill_acc_rdy", issue_ready, 1);
    step();
    issue_valid = 0;
    repeat (3) step();
    kill = 1;
    #1 check("kill_busy", busy, 1);
    step();
    kill = 0;
    #1 check("kill_back_idle", issue_ready, 1);
    step();
    exe_ready = 1; exe_result = 32'h0000bbbb;
    step();
    exe_ready = 0;
    #1 check("kill_head_kept", {wb_waddr, wb_wdata}, {5'd20, 32'h0000aaaa});
    wb_ready = 1;
    #1 check("kill_old_wb", fwb_wren, 1);
    step();
    check("kill_nothing_pushed", {busy, fwb_wren}, 2'b00);

    // Watchdog
    issue_valid = 1; issue_waddr = 5'd5;
    step();
    issue_valid = 0;
    #1 check("wd_enable", exe_enable, 1);
    first = -1;
    i = 0;
    while (first < 0 && i < 300) begin
      step();
      i++;
      if (timeout) first = i;
    end
    check("wd_cycles", first, 256);
    check("wd_idle", {busy, fwb_wren}, 2'b00);
    step();
    check("wd_pulse_end", timeout, 0);

    // Reset mid-WAIT with a buffered entry
    wb_ready = 0;
    do_op(5'd25, 32'h0000cccc, 5'h3, 1'b1, 0);
    issue_valid = 1; issue_waddr = 5'd26; issue_data1 = 32'h00000055;
    step();
    issue_valid = 0;
    repeat (2) step();
    check("mid_pre_rst", {busy, fwb_wren, exe_data1}, {1'b1, 1'b1, 32'h00000055});
    cur_fflags = 5'h1f; wb_ready = 1;
    #2 rst = 1'b0;
    #1;
    check("mr_issue_ready", issue_ready, 0);
    check("mr_exe", {exe_enable, exe_op, exe_rm}, 0);
    check("mr_exe_data", exe_data1, 0);
    check("mr_wb", {fwb_wren, iwb_wren, wb_waddr}, 0);
    check("mr_wdata", wb_wdata, 0);
    check("mr_flags", {flags_valid, flags}, 0);
    check("mr_pulses_busy", {illegal, timeout, busy}, 0);
    #1 rst = 1'b1;
    step();
    check("mr_release_ready", issue_ready, 1);
    check("mr_release_empty", {busy, fwb_wren}, 2'b00);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
